// File: rtl/cycle_sequencer_pkg.sv
// Shared types and constants for the instruction cycle sequencer and its decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cycle_sequencer_pkg;

   // Default number of execute ck/stb pairs available to one instruction
   localparam int MAX_STEPS_DEF = 6;

   // Address the decoder jumps to (forced JMS) when an interrupt is serviced
   localparam logic [11:0] IRQ_VECTOR = 12'o0000;

   typedef enum logic [2:0] {
      S_HALT,
      S_FETCH_CK,
      S_FETCH_STB,
      S_EXEC_CK,
      S_EXEC_STB,
      S_ERR
   } state_t;

endpackage

// File: rtl/cycle_sequencer_phase_decoder.sv
// Turns the sequencer state plus step index into one-hot execute ck/stb vectors.
// Latency: combinational; outputs follow the registered state/step directly.
// Backpressure: none.
module cycle_sequencer_phase_decoder
   import cycle_sequencer_pkg::*;
#(
   parameter int MAX_STEPS = MAX_STEPS_DEF,
   parameter int SW        = $clog2(MAX_STEPS + 1)
) (
   input  state_t               state,
   input  logic [SW-1:0]        step,
   output logic [MAX_STEPS-1:0] ck,
   output logic [MAX_STEPS-1:0] stb
);

   localparam logic [MAX_STEPS-1:0] ONE = MAX_STEPS'(1);

   logic [MAX_STEPS-1:0] onehot;

   // step is 1-based, so step 1 maps to bit 0
   always_comb begin
      onehot = ONE << (step - SW'(1));
   end

   // Only execute phases drive ck/stb; fetch, halt and error keep both at zero
   always_comb begin
      ck  = '0;
      stb = '0;
      if (state == S_EXEC_CK)  ck  = onehot;
      if (state == S_EXEC_STB) stb = onehot;
   end

endmodule

// File: rtl/cycle_sequencer.sv
// Fetch/execute timing generator feeding the memory-reference control decoder.
// Latency: 1 clock from run/step_req to fetch; instruction = fetch + ck/stb steps until done.
// Backpressure: done from the decoder closes the instruction; no done by the last step traps to ERR.
module cycle_sequencer
   import cycle_sequencer_pkg::*;
#(
   parameter int MAX_STEPS = MAX_STEPS_DEF,
   parameter int CK_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic                 step_req,
   input  logic                 irq,
   input  logic                 irq_en,
   input  logic                 done,
   output logic [MAX_STEPS-1:0] ck,
   output logic [MAX_STEPS-1:0] stb,
   output logic                 pc2rama,
   output logic                 fetch_oe,
   output logic                 ir_ck,
   output logic                 pc_inc,
   output logic                 irq_override,
   output logic                 irq_ack,
   output logic                 busy,
   output logic                 overrun
);

   localparam int            SW        = $clog2(MAX_STEPS + 1);
   localparam logic [SW-1:0] STEP_ONE  = SW'(1);
   localparam logic [SW-1:0] STEP_MAX  = SW'(MAX_STEPS);
   localparam logic [3:0]    HOLD_LAST = 4'(CK_CYCLES - 1);

   state_t        state,     state_n;
   logic [SW-1:0] step,      step_n;
   logic [3:0]    hold,      hold_n;
   logic          single_q,  single_n;
   logic          ovr_q,     ovr_n;
   logic          overrun_q, overrun_n;
   logic          take_irq;
   logic          hold_last;

   assign hold_last = (hold == HOLD_LAST);

   // State register: reset aborts any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_HALT;
         step      <= STEP_ONE;
         hold      <= '0;
         single_q  <= 1'b0;
         ovr_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state     <= state_n;
         step      <= step_n;
         hold      <= hold_n;
         single_q  <= single_n;
         ovr_q     <= ovr_n;
         overrun_q <= overrun_n;
      end
   end

   // Next-state logic, including the instruction-boundary decision on done
   always_comb begin
      state_n   = state;
      step_n    = step;
      hold_n    = hold;
      single_n  = single_q;
      ovr_n     = ovr_q;
      overrun_n = overrun_q;
      take_irq  = 1'b0;
      case (state)
         S_HALT: begin
            if (step_req) begin
               state_n  = S_FETCH_CK;
               single_n = 1'b1;
               hold_n   = '0;
            end else if (run) begin
               state_n  = S_FETCH_CK;
               single_n = 1'b0;
               hold_n   = '0;
            end
         end
         S_FETCH_CK: begin
            if (hold_last) begin
               hold_n  = '0;
               state_n = S_FETCH_STB;
            end else begin
               hold_n = hold + 4'd1;
            end
         end
         S_FETCH_STB: begin
            state_n = S_EXEC_CK;
            step_n  = STEP_ONE;
            hold_n  = '0;
         end
         S_EXEC_CK: begin
            if (!hold_last) begin
               hold_n = hold + 4'd1;
            end else begin
               hold_n = '0;
               if (done) begin
                  step_n = STEP_ONE;
                  if (single_q || !run) begin
                     state_n  = S_HALT;
                     single_n = 1'b0;
                     ovr_n    = 1'b0;
                  end else if (irq && irq_en && !ovr_q) begin
                     take_irq = 1'b1;
                     ovr_n    = 1'b1;
                     state_n  = S_FETCH_CK;
                  end else begin
                     ovr_n   = 1'b0;
                     state_n = S_FETCH_CK;
                  end
               end else begin
                  state_n = S_EXEC_STB;
               end
            end
         end
         S_EXEC_STB: begin
            if (step == STEP_MAX) begin
               state_n   = S_ERR;
               overrun_n = 1'b1;
            end else begin
               step_n  = step + STEP_ONE;
               state_n = S_EXEC_CK;
            end
         end
         S_ERR: begin
            state_n = S_ERR;
         end
         default: begin
            state_n = S_HALT;
         end
      endcase
   end

   // Phase outputs decoded from registered state; irq_ack marks the boundary clock itself
   always_comb begin
      pc2rama      = (state == S_FETCH_CK) || (state == S_FETCH_STB);
      fetch_oe     = (state == S_FETCH_CK) || (state == S_FETCH_STB);
      ir_ck        = (state == S_FETCH_STB) && !ovr_q;
      pc_inc       = (state == S_FETCH_STB) && !ovr_q;
      irq_override = ovr_q;
      irq_ack      = take_irq;
      busy         = (state != S_HALT) && (state != S_ERR);
      overrun      = overrun_q;
   end

   cycle_sequencer_phase_decoder #(
      .MAX_STEPS (MAX_STEPS),
      .SW        (SW)
   ) u_phase_decoder (
      .state (state),
      .step  (step),
      .ck    (ck),
      .stb   (stb)
   );

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: per-clock expected outputs queued, then compared.
// Latency: n/a.
// Backpressure: n/a.
module tb_cycle_sequencer;

   localparam int MS    = 6;
   localparam int NEVER = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic run = 1'b0, step_req = 1'b0, irq = 1'b0, irq_en = 1'b0, done = 1'b0;
   logic run_b = 1'b0, done_b = 1'b0;

   logic [MS-1:0] ck_a, stb_a, ck_b, stb_b;
   logic pc2rama_a, fetch_oe_a, ir_ck_a, pc_inc_a, irq_override_a, irq_ack_a, busy_a, overrun_a;
   logic pc2rama_b, fetch_oe_b, ir_ck_b, pc_inc_b, irq_override_b, irq_ack_b, busy_b, overrun_b;

   typedef struct packed {
      logic [MS-1:0] ck;
      logic [MS-1:0] stb;
      logic pc2rama;
      logic fetch_oe;
      logic ir_ck;
      logic pc_inc;
      logic irq_override;
      logic irq_ack;
      logic busy;
      logic overrun;
   } obs_t;

   typedef struct {
      obs_t exp;
      logic d;
      logic r;
      logic q;
      logic s;
   } ent_t;

   ent_t sb[$];
   int   checks = 0;
   int   errors = 0;

   obs_t obs_a, obs_b;
   assign obs_a = {ck_a, stb_a, pc2rama_a, fetch_oe_a, ir_ck_a, pc_inc_a,
                   irq_override_a, irq_ack_a, busy_a, overrun_a};
   assign obs_b = {ck_b, stb_b, pc2rama_b, fetch_oe_b, ir_ck_b, pc_inc_b,
                   irq_override_b, irq_ack_b, busy_b, overrun_b};

   cycle_sequencer #(.MAX_STEPS(MS), .CK_CYCLES(1)) dut_a (
      .clk (clk), .rst_n (rst_n), .run (run), .step_req (step_req), .irq (irq),
      .irq_en (irq_en), .done (done), .ck (ck_a), .stb (stb_a), .pc2rama (pc2rama_a),
      .fetch_oe (fetch_oe_a), .ir_ck (ir_ck_a), .pc_inc (pc_inc_a),
      .irq_override (irq_override_a), .irq_ack (irq_ack_a), .busy (busy_a),
      .overrun (overrun_a)
   );

   cycle_sequencer #(.MAX_STEPS(MS), .CK_CYCLES(3)) dut_b (
      .clk (clk), .rst_n (rst_n), .run (run_b), .step_req (1'b0), .irq (1'b0),
      .irq_en (1'b0), .done (done_b), .ck (ck_b), .stb (stb_b), .pc2rama (pc2rama_b),
      .fetch_oe (fetch_oe_b), .ir_ck (ir_ck_b), .pc_inc (pc_inc_b),
      .irq_override (irq_override_b), .irq_ack (irq_ack_b), .busy (busy_b),
      .overrun (overrun_b)
   );

   function automatic obs_t mk(int ck_i, int stb_i, bit fch, bit irs, bit ovr,
                               bit ack, bit bsy, bit ovf);
      obs_t o;
      o = '0;
      if (ck_i > 0)  o.ck[ck_i-1]   = 1'b1;
      if (stb_i > 0) o.stb[stb_i-1] = 1'b1;
      o.pc2rama      = fch;
      o.fetch_oe     = fch;
      o.ir_ck        = irs;
      o.pc_inc       = irs;
      o.irq_override = ovr;
      o.irq_ack      = ack;
      o.busy         = bsy;
      o.overrun      = ovf;
      return o;
   endfunction

   task automatic push(obs_t e, logic d, logic r, logic q, logic s);
      ent_t t;
      t.exp = e; t.d = d; t.r = r; t.q = q; t.s = s;
      sb.push_back(t);
   endtask

   task automatic push_halt(int n, logic r, logic q);
      for (int i = 0; i < n; i++) push(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, r, q, 1'b0);
   endtask

   // One instruction: fetch, then ck/stb steps; done driven on the last clock of ck[done_at]
   // (done_at=0 means never). irq is high from cycle irq_from, step_req pulsed at step_at.
   task automatic push_instr(int cyc, int done_at, bit ovr, bit ack, logic r,
                             int irq_from, int step_at);
      int n;
      bit last;
      n = 0;
      for (int i = 0; i < cyc; i++) begin
         push(mk(0, 0, 1, 0, ovr, 0, 1, 0), 1'b0, r, n >= irq_from, n == step_at);
         n++;
      end
      push(mk(0, 0, 1, !ovr, ovr, 0, 1, 0), 1'b0, r, n >= irq_from, n == step_at);
      n++;
      for (int k = 1; k <= MS; k++) begin
         for (int i = 0; i < cyc; i++) begin
            last = (k == done_at) && (i == cyc - 1);
            push(mk(k, 0, 0, 0, ovr, last && ack, 1, 0), last, r, n >= irq_from, n == step_at);
            n++;
         end
         if (k == done_at) break;
         push(mk(0, k, 0, 0, ovr, 0, 1, 0), 1'b0, r, n >= irq_from, n == step_at);
         n++;
      end
   endtask

   // Pops one entry per clock: drive its inputs at the falling edge, compare 1 time unit later
   task automatic run_queue(bit sel, int nmax, string name);
      int   n;
      ent_t t;
      obs_t got;
      n = 0;
      while (sb.size() > 0 && n < nmax) begin
         @(negedge clk);
         t = sb.pop_front();
         if (sel) begin
            done_b = t.d; run_b = t.r;
         end else begin
            done = t.d; run = t.r; irq = t.q; step_req = t.s;
         end
         #1;
         got = sel ? obs_b : obs_a;
         checks++;
         if (got !== t.exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", name, n, got, t.exp);
         end
         n++;
      end
      sb.delete();
      done = 1'b0; done_b = 1'b0; step_req = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs_a !== '0) begin errors++; $display("FAIL reset_a: got %h want 0", obs_a); end
      checks++;
      if (obs_b !== '0) begin errors++; $display("FAIL reset_b: got %h want 0", obs_b); end
      rst_n = 1'b1;
      push_halt(2, 1'b0, 1'b0);
      run_queue(0, 100, "idle_halt");
   endtask

   task automatic test_basic_run();
      @(negedge clk); run = 1'b1;
      push_instr(1, 2, 0, 0, 1'b1, NEVER, -1);
      push_instr(1, 2, 0, 0, 1'b1, NEVER, -1);
      push_instr(1, 2, 0, 0, 1'b0, NEVER, -1);
      push_halt(2, 1'b0, 1'b0);
      run_queue(0, 100, "basic_run");
   endtask

   task automatic test_ck_cycles();
      @(negedge clk); run_b = 1'b1;
      push_instr(3, 4, 0, 0, 1'b1, NEVER, -1);
      push_instr(3, 4, 0, 0, 1'b0, NEVER, -1);
      push_halt(2, 1'b0, 1'b0);
      run_queue(1, 100, "ck_cycles3");
   endtask

   task automatic test_single_step();
      push(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1);
      push_instr(1, 3, 0, 0, 1'b0, NEVER, 2);
      push_halt(3, 1'b0, 1'b0);
      push(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b1);
      push_instr(1, 3, 0, 0, 1'b0, NEVER, -1);
      push_halt(2, 1'b0, 1'b0);
      run_queue(0, 100, "single_step");
   endtask

   task automatic test_irq();
      irq_en = 1'b1;
      @(negedge clk); run = 1'b1;
      push_instr(1, 2, 0, 1, 1'b1, 3, -1);
      push_instr(1, 2, 1, 0, 1'b1, 0, -1);
      push_instr(1, 2, 0, 0, 1'b0, 0, -1);
      push_halt(2, 1'b0, 1'b1);
      run_queue(0, 100, "irq");
      irq = 1'b0; irq_en = 1'b0;
   endtask

   task automatic test_overrun();
      @(negedge clk); run = 1'b1;
      push_instr(1, 0, 0, 0, 1'b1, NEVER, -1);
      for (int i = 0; i < 4; i++)
         push(mk(0, 0, 0, 0, 0, 0, 0, 1), 1'b0, (i % 2) == 0, 1'b0, i == 1);
      run_queue(0, 100, "overrun");
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs_a !== '0) begin errors++; $display("FAIL err_clear: got %h want 0", obs_a); end
      @(negedge clk); rst_n = 1'b1; run = 1'b1;
      push_instr(1, 0, 0, 0, 1'b1, NEVER, -1);
      run_queue(0, 7, "pre_reset");
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs_a !== '0) begin errors++; $display("FAIL async_reset: got %h want 0", obs_a); end
      @(negedge clk); rst_n = 1'b1;
      push_instr(1, 2, 0, 0, 1'b0, NEVER, -1);
      push_halt(2, 1'b0, 1'b0);
      run_queue(0, 100, "post_reset");
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_ck_cycles();
      test_single_step();
      test_irq();
      test_overrun();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Timing/state generator directly upstream of the memory-reference instruction control decoder.
- Runs the instruction fetch: PC to RAM address, IR load, PC increment.
- Then emits the one-hot execute phase pulses ck1..ckN / stb1..stbN that the decoder ANDs with the opcode, and consumes the decoder's done to close the instruction.
- Also owns run/halt/single-step control, interrupt entry and a phase-overrun trap.

Parameters:
- MAX_STEPS, 6, number of execute steps (ck/stb pairs) available per instruction.
- CK_CYCLES, 1, clocks each ck phase (fetch and execute) is held, for slow RAM; range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = free-running execution.
- step_req  in  1  one-clock pulse; execute exactly one instruction from HALT.
- irq  in  1  level interrupt request.
- irq_en  in  1  interrupt enable (ION).
- done  in  1  from decoder; instruction complete.
- ck  out  MAX_STEPS  one-hot execute ck phase; bit0 = ck1.
- stb  out  MAX_STEPS  one-hot execute strobe phase; bit0 = stb1.
- pc2rama  out  1  fetch: PC drives RAM address.
- fetch_oe  out  1  fetch: RAM output enable.
- ir_ck  out  1  fetch strobe: load IR.
- pc_inc  out  1  fetch strobe: PC+1.
- irq_override  out  1  held for the whole instruction that services an interrupt.
- irq_ack  out  1  one-clock pulse when an interrupt is taken.
- busy  out  1  1 in any state except HALT and ERR.
- overrun  out  1  sticky trap flag.

Behaviour:
- States: HALT, FETCH_CK, FETCH_STB, EXEC_CK, EXEC_STB, ERR. Registered outputs; state, step index (1..MAX_STEPS) and hold counter (0..CK_CYCLES-1).
- Reset (async, rst_n=0): state HALT, step=1, hold=0, every output 0, overrun=0. Reset mid-instruction aborts immediately; no partial strobes after release.
- HALT:
  - run=1 or step_req=1 → FETCH_CK next clock.
  - step_req is latched as single-step mode for that instruction.
- FETCH_CK: pc2rama=fetch_oe=1 for CK_CYCLES clocks, then FETCH_STB.
- FETCH_STB:
  - Exactly one clock; ir_ck=pc_inc=1, pc2rama/fetch_oe stay 1.
  - If irq_override=1, ir_ck and pc_inc are 0: the decoder sees a forced JMS 0 and PC is not advanced.
  - Next state EXEC_CK, step=1.
- EXEC_CK: ck[step-1]=1 for CK_CYCLES clocks. done is sampled on the last clock of the phase.
  - done=1 → instruction boundary.
  - done=0 → EXEC_STB.
- EXEC_STB: stb[step-1]=1 for exactly one clock.
  - step<MAX_STEPS → step+1, EXEC_CK.
  - step=MAX_STEPS → ERR, overrun=1.
- done is ignored outside EXEC_CK and outside the sampling clock.
- At most one bit of ck|stb is set at any time. ck and stb are never asserted during fetch.
- Instruction boundary, evaluated on the clock done is sampled; exactly one of the following applies:
  - Single-step mode, or run=0 → HALT (single-step mode cleared).
  - Otherwise, irq=1 and irq_en=1 and irq_override=0 → irq_ack pulses this clock; irq_override=1 from the next clock through the next instruction's done; FETCH_CK.
  - Otherwise → FETCH_CK. irq_override clears at this boundary.
- Simultaneous events:
  - run falling mid-instruction: the instruction completes and then halts.
  - step_req while busy: ignored.
  - irq with run=0: not taken; re-evaluated at the next boundary.
- ERR: all phase outputs 0, busy=0. Leaves only via rst_n.
- Minimum instruction length with CK_CYCLES=1 and done at ck2: FETCH_CK, FETCH_STB, ck1, stb1, ck2 = 5 clocks, back-to-back with no gap.

Decomposition:
- Shared package:
  - state enum (HALT, FETCH_CK, FETCH_STB, EXEC_CK, EXEC_STB, ERR);
  - MAX_STEPS default;
  - IRQ vector address constant (0) used by the decoder.
- One sub-module, phase_decoder: converts step index + state into the one-hot ck/stb vectors.

Test Plan:
- Reset then run=1, done forced at ck2 → sequence FETCH_CK, FETCH_STB(ir_ck=pc_inc=1), ck=000001, stb=000001, ck=000010, then FETCH_CK again; 5 clocks/instruction.
- CK_CYCLES=3, done at ck4 → each ck held 3 clocks, each stb 1 clock; instruction = 3+1+4·3+3·1 = 19 clocks.
- HALT, single step_req pulse, done at ck3 → exactly one instruction; busy high 7 clocks, then HALT; a second step_req runs the next one.
- run=1, irq_en=1, irq raised mid-instruction → irq_ack one clock at done; next fetch has ir_ck=pc_inc=0, irq_override=1 until its done; irq still high is not retaken while irq_override=1.
- done never asserted, MAX_STEPS=6 → after stb6, overrun=1, ck=stb=0, busy=0; run toggling has no effect until rst_n pulse clears it.
- rst_n asserted during ck3 → all outputs 0 asynchronously; after release with run=1 a fresh fetch starts at step 1.
